// File: rtl/dbus_sram_responder_if.sv
// Request/response bundle between a memory-stage master and a dbus responder.
// The error flag travels with the response so the whole handshake is one port.
interface dbus_sram_responder_if;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   dbus_req_t  dreq;
   dbus_resp_t dresp;
   logic       err;

   modport master (output dreq, input dresp, input err);
   modport slave  (input dreq, output dresp, output err);

endinterface

// File: rtl/dbus_sram_responder.sv
// Memory-side dbus responder: one outstanding load/store, fixed access latency,
// byte-strobed read-modify-write on a 64-bit-wide RAM, single-cycle completion.
module dbus_sram_responder #(
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          DEPTH   = 4096,
   parameter int          LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   dbus_sram_responder_if.slave bus
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [3:0]    cnt_r;
   logic [3:0]    cnt_s;
   logic          accept_s;
   logic          access_s;

   logic [63:0]   addr_r;
   logic [2:0]    size_r;
   logic [7:0]    strobe_r;
   logic [63:0]   wdata_r;

   logic [63:0]   offset_s;
   logic          out_of_range_s;
   logic          reject_s;
   logic [AW-1:0] index_s;
   logic [63:0]   old_word_s;

   logic          addr_ok_r;
   logic          data_ok_r;
   logic          err_r;
   logic [63:0]   rdata_r;

   logic [63:0]   mem [DEPTH];

   function automatic logic misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
      logic bad;
      case (size)
         3'd1:    bad = addr_lo[0];
         3'd2:    bad = (addr_lo[1:0] != 2'b00);
         3'd3:    bad = (addr_lo != 3'b000);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Decode of the latched request: window check, alignment check, word index.
   always_comb begin
      offset_s       = addr_r - BASE;
      out_of_range_s = (addr_r < BASE) || (offset_s >= SPAN);
      reject_s       = out_of_range_s || misaligned(addr_r[2:0], size_r);
      index_s        = offset_s[AW+2:3];
      old_word_s     = mem[index_s];
   end

   // Next-state logic; access_s marks the BUSY->DONE edge where the RAM is touched.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      access_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.dreq.valid) begin
               accept_s = 1'b1;
               cnt_s    = CNT_LOAD;
               state_s  = BUSY;
            end else begin
               state_s  = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == 4'd0) begin
               access_s = 1'b1;
               state_s  = DONE;
            end else begin
               cnt_s    = cnt_r - 4'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, counter and registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         addr_ok_r <= 1'b0;
         data_ok_r <= 1'b0;
         err_r     <= 1'b0;
         rdata_r   <= 64'd0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         addr_ok_r <= access_s;
         data_ok_r <= access_s;
         err_r     <= access_s & reject_s;
         rdata_r   <= (access_s && !reject_s) ? old_word_s : 64'd0;
      end
   end

   // Request capture; dreq is ignored from acceptance until the FSM is idle again.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r   <= 64'd0;
         size_r   <= 3'd0;
         strobe_r <= 8'd0;
         wdata_r  <= 64'd0;
      end else if (accept_s) begin
         addr_r   <= bus.dreq.addr;
         size_r   <= bus.dreq.size;
         strobe_r <= bus.dreq.strobe;
         wdata_r  <= bus.dreq.data;
      end
   end

   // Byte-strobed write, blocked for rejected accesses and edges with reset high.
   always_ff @(posedge clk) begin
      if (!reset && access_s && !reject_s) begin
         for (int i = 0; i < 8; i++) begin
            if (strobe_r[i]) begin
               mem[index_s][i*8 +: 8] <= wdata_r[i*8 +: 8];
            end
         end
      end
   end

   assign bus.dresp = {addr_ok_r, data_ok_r, rdata_r};
   assign bus.err   = err_r;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: directed stimulus pushes expected
// completions, a negedge monitor pops and compares each data_ok pulse.
module tb_dbus_sram_responder;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          DEPTH = 4096;
   localparam int          LAT   = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      logic [63:0] data;
      logic        err;
      logic        chk;
      int          due;
   } exp_t;

   exp_t sb[$];

   dbus_sram_responder_if bus ();
   dbus_sram_responder_if bus1 ();
   dbus_sram_responder_if bus15 ();

   dbus_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   dbus_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   dbus_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(15)) dut15 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus15)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every data_ok must match the oldest expectation; otherwise outputs are zero.
   always @(negedge clk) begin
      exp_t e;
      if (bus.dresp.data_ok === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL spurious_data_ok cycle=%0d data=%h err=%0b required=no_response",
                     cyc, bus.dresp.data, bus.err);
         end else begin
            e = sb.pop_front();
            if (cyc != e.due || bus.dresp.addr_ok !== 1'b1 || bus.err !== e.err ||
                (e.chk && bus.dresp.data !== e.data)) begin
               failures++;
               $display("FAIL resp cycle=%0d/%0d addr_ok=%0b/1 err=%0b/%0b data=%h/%h chk=%0b",
                        cyc, e.due, bus.dresp.addr_ok, bus.err, e.err,
                        bus.dresp.data, e.data, e.chk);
            end
         end
      end else if (cyc > 1) begin
         checks++;
         if (bus.dresp !== '0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs cycle=%0d dresp=%h err=%0b required=0",
                     cyc, bus.dresp, bus.err);
         end
      end
   end

   task automatic drive(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                        input logic [63:0] d);
      bus.dreq.addr   = a;
      bus.dreq.size   = sz;
      bus.dreq.strobe = st;
      bus.dreq.data   = d;
      bus.dreq.valid  = 1'b1;
   endtask

   task automatic scramble();
      bus.dreq.valid  = 1'b0;
      bus.dreq.addr   = ~bus.dreq.addr;
      bus.dreq.size   = 3'd3;
      bus.dreq.strobe = 8'hFF;
      bus.dreq.data   = 64'hFEED_FACE_0BAD_F00D;
   endtask

   // One request; returns at the first cycle the DUT can accept the next one.
   task automatic issue(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                        input logic [63:0] d, input logic [63:0] ed, input logic ee,
                        input logic chk);
      int c0;
      c0 = cyc;
      drive(a, sz, st, d);
      sb.push_back('{ed, ee, chk, c0 + 1 + LAT});
      @(negedge clk);
      scramble();
      repeat (LAT + 1) @(negedge clk);
   endtask

   // valid held across two acceptances of the same request.
   task automatic held(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                       input logic [63:0] d, input logic [63:0] e1, input logic [63:0] e2);
      int c0;
      c0 = cyc;
      drive(a, sz, st, d);
      sb.push_back('{e1, 1'b0, 1'b1, c0 + 1 + LAT});
      sb.push_back('{e2, 1'b0, 1'b1, c0 + 2 * LAT + 3});
      repeat (LAT + 3) @(negedge clk);
      scramble();
      repeat (LAT + 1) @(negedge clk);
   endtask

   // Store abandoned by reset asserted while the FSM is in BUSY.
   task automatic reset_in_busy(input logic [63:0] a, input logic [63:0] d);
      drive(a, 3'd3, 8'hFF, d);
      @(negedge clk);
      scramble();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.dresp !== '0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_busy dresp=%h err=%0b required=0", bus.dresp, bus.err);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int c0;
      int got1;
      int got15;
      logic err1;
      logic err15;
      logic [63:0] dat1;
      logic [63:0] dat15;

      bus.dreq   = '0;
      bus1.dreq  = '0;
      bus15.dreq = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.dresp !== '0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state dresp=%h err=%0b required=0", bus.dresp, bus.err);
      end

      // store then load
      issue(BASE + 64'h8, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 1'b0);
      issue(BASE + 64'h8, 3'd3, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
      // byte and half strobes; each store returns the old word
      issue(BASE + 64'hB, 3'd0, 8'h08, 64'h0000_0000_AB00_0000, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
      issue(BASE + 64'hC, 3'd1, 8'h30, 64'h0000_CDEF_0000_0000, 64'h1122_3344_AB66_7788, 1'b0, 1'b1);
      issue(BASE + 64'h8, 3'd3, 8'h00, 64'd0, 64'h1122_CDEF_AB66_7788, 1'b0, 1'b1);
      // rejections
      issue(BASE - 64'h8, 3'd3, 8'h00, 64'd0, 64'd0, 1'b1, 1'b1);
      issue(BASE, 3'd3, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0, 1'b0, 1'b0);
      issue(BASE + 64'h2, 3'd2, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
      issue(BASE + 64'h4, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
      issue(BASE + 64'h1, 3'd1, 8'h02, 64'h0000_0000_0000_FF00, 64'd0, 1'b1, 1'b1);
      issue(BASE, 3'd3, 8'h00, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1'b1);
      // held valid: second transaction sees the first one's write
      held(BASE + 64'h8, 3'd0, 8'h01, 64'h0000_0000_0000_0077,
           64'h1122_CDEF_AB66_7788, 64'h1122_CDEF_AB66_7777);
      // reset mid-flight leaves the word unchanged
      reset_in_busy(BASE + 64'h8, 64'hDEAD_BEEF_DEAD_BEEF);
      issue(BASE + 64'h8, 3'd3, 8'h00, 64'd0, 64'h1122_CDEF_AB66_7777, 1'b0, 1'b1);
      // top of the window
      issue(BASE + 64'h7FF8, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 1'b0);
      issue(BASE + 64'h7FF8, 3'd3, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
      issue(BASE + 64'h8000, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
      issue(BASE, 3'd3, 8'h00, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1'b1);

      // latency sweep on the LATENCY=1 and LATENCY=15 builds
      c0    = cyc;
      got1  = -1;
      got15 = -1;
      err1  = 1'b0;
      err15 = 1'b0;
      dat1  = 64'd0;
      dat15 = 64'd0;
      bus1.dreq  = '{1'b1, BASE - 64'h8, 3'd3, 8'h00, 64'd0};
      bus15.dreq = '{1'b1, BASE - 64'h8, 3'd3, 8'h00, 64'd0};
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus1.dreq.valid  = 1'b0;
         bus15.dreq.valid = 1'b0;
         if (got1 < 0 && bus1.dresp.data_ok === 1'b1) begin
            got1 = cyc;
            err1 = bus1.err;
            dat1 = bus1.dresp.data;
         end
         if (got15 < 0 && bus15.dresp.data_ok === 1'b1) begin
            got15 = cyc;
            err15 = bus15.err;
            dat15 = bus15.dresp.data;
         end
      end
      checks++;
      if (got1 != c0 + 2 || err1 !== 1'b1 || dat1 !== 64'd0) begin
         failures++;
         $display("FAIL latency1 cycle=%0d/%0d err=%0b/1 data=%h/0", got1, c0 + 2, err1, dat1);
      end
      checks++;
      if (got15 != c0 + 16 || err15 !== 1'b1 || dat15 !== 64'd0) begin
         failures++;
         $display("FAIL latency15 cycle=%0d/%0d err=%0b/1 data=%h/0", got15, c0 + 16, err15, dat15);
      end

      repeat (5) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL pending_responses count=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Data-bus responder: the memory-side end of the `dbus_req_t`/`dbus_resp_t` protocol the pipeline's memory stage issues on. It accepts one load/store at a time, models a fixed access latency with a down-counter, performs a byte-strobed read-modify-write on an internal 64-bit-wide RAM, and returns a single-cycle completion. It is used as a standalone backing store for core bring-up and as the reference target in memory-stage verification.

## Interface
- `BASE`, 64'h8000_0000, byte address mapped to RAM word 0.
- `DEPTH`, 4096, number of 64-bit RAM words; power of two.
- `LATENCY`, 2, cycles spent in BUSY; legal range 1..15.
- `clk`  input  1  clock; one clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `dreq`  input  `dbus_req_t`  fields `valid`, `addr[63:0]`, `size[2:0]` (0=B,1=H,2=W,3=D), `strobe[7:0]`, `data[63:0]`.
- `dresp`  output  `dbus_resp_t`  fields `addr_ok`, `data_ok`, `data[63:0]`.
- `err`  output  1  pulses with `data_ok` when the access was rejected.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: when `dreq.valid`=1, latch `addr`, `size`, `strobe`, `data`; load counter with `LATENCY-1`; go to BUSY. Otherwise stay.
- BUSY: if counter is 0, perform the access and go to DONE; otherwise decrement.
- DONE: drive `addr_ok`=`data_ok`=1 for exactly this cycle; go to IDLE.
- Word index = `(addr - BASE) >> 3`, low `log2(DEPTH)` bits.
- Access, performed on the BUSY→DONE edge:
  - Capture the full aligned 64-bit word before the write into the response register. Reads and writes both return the old word.
  - For each byte i with `strobe[i]`=1, write `data[8i+7:8i]` into byte i of the word.
  - `size` is used only for the alignment check. `strobe` alone selects which bytes are written.
- Rejection: the access is suppressed (no RAM write, `dresp.data`=0, `err`=1 in DONE) if either:
  - the address is outside `[BASE, BASE+8*DEPTH)`, or
  - the address is misaligned for `size`: H needs `addr[0]`=0, W needs `addr[1:0]`=0, D needs `addr[2:0]`=0.
- The latched request is authoritative. Changes on `dreq` after acceptance are ignored until the FSM returns to IDLE.
- `dreq.valid` held high in the DONE cycle is not a new request. It is re-sampled in IDLE on the next cycle, which matches the core holding `valid` until it sees `data_ok`.

## Timing
- Reset (synchronous): next state IDLE; counter cleared; `addr_ok`, `data_ok`, `err` = 0; `dresp.data` = 0. RAM contents are not reset.
- Reset asserted while in BUSY or DONE: the in-flight access is abandoned. No RAM write occurs unless the BUSY→DONE edge fell in a cycle where `reset` was low.
- Latency: `valid` sampled in IDLE at cycle T gives `data_ok` at cycle T+1+LATENCY. With `LATENCY`=2, `data_ok` is at T+3.
- Throughput: one request per LATENCY+2 cycles. With a back-to-back held request, the second is accepted at cycle T+2+LATENCY.
- `addr_ok`, `data_ok`, `err` and `dresp.data` are registered outputs, stable for the whole DONE cycle and 0 outside DONE (`data` is 0 outside DONE).
- Read-after-write to the same word in consecutive transactions returns the written value. The write completes before the next request is accepted.

## Test plan
- Store then load: store addr=BASE+8, size=D, strobe=FF, data=0x1122334455667788; then load the same address with strobe=00. The load returns 0x1122334455667788. Each `data_ok` arrives exactly LATENCY+1 cycles after acceptance.
- Byte/half strobes: after the word above, store addr=BASE+0xB, size=B, strobe=08, data=0xAB<<24; then store addr=BASE+0xC, size=H, strobe=30, data=0xCDEF<<32. A read returns 0x1122CDEFAB667788.
- Errors: load at BASE-8 gives `err`=1 and data=0. Store W at BASE+2 gives `err`=1, and a follow-up read of BASE shows that word unchanged.
- Held valid: keep `valid` high across two transactions. Exactly one `data_ok` pulse per transaction, separated by LATENCY+2 cycles, with no duplicate write.
- Mid-flight reset: assert `reset` during BUSY of a store. All outputs are 0 the next cycle, a later read shows the word unchanged, and the next request completes normally.
- Latency sweep: `LATENCY`=1 and `LATENCY`=15 builds meet the T+1+LATENCY timing. The last word, BASE+8*(DEPTH-1), is accessible and BASE+8*DEPTH is rejected.
